// File: rtl/procesador_fifo_pkg.sv
// Shared definitions for the HPS<->fabric FIFO bridges: MM address map,
// status word bit positions and the control bit used for a soft flush.
package procesador_fifo_pkg;

  // Avalon-MM word addresses seen by the HPS master
  typedef enum logic {
    ADDR_DATA   = 1'b0,
    ADDR_STATUS = 1'b1
  } mm_addr_e;

  // Status word layout: {24'b0, full, empty, 1'b0, level[4:0]}
  localparam int LEVEL_LSB      = 0;
  localparam int STATUS_LEVEL_W = 5;
  localparam int EMPTY_BIT      = 6;
  localparam int FULL_BIT       = 7;

  // Control word layout for writes to the status address
  localparam int FLUSH_BIT = 0;

  // Assemble the 32-bit status word from the FIFO flags and fill level
  function automatic logic [31:0] packStatus(
    input logic                      full,
    input logic                      empty,
    input logic [STATUS_LEVEL_W-1:0] level
  );
    logic [31:0] status;
    status                                = '0;
    status[FULL_BIT]                      = full;
    status[EMPTY_BIT]                     = empty;
    status[LEVEL_LSB +: STATUS_LEVEL_W]   = level;
    return status;
  endfunction

endpackage

// File: rtl/fifo_regs_fwft.sv
// Register-array FIFO with first-word-fall-through output. Holds the
// storage, read/write pointers and fill count; the caller decides when a
// push, a flush or a downstream ready is presented.
module fifo_regs_fwft #(
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = $clog2(DEPTH) + 1,
  parameter int DATA_W  = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_push,
  input  logic [DATA_W-1:0]  i_wdata,
  input  logic               i_ready,
  input  logic               i_flush,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_valid,
  output logic               o_full,
  output logic               o_empty,
  output logic [LEVEL_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [LEVEL_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Flags come only from the registered count so the MM side never sees
  // a path from the downstream ready.
  assign w_full  = (r_count == LEVEL_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // A full FIFO drops the push (the top stalls the master instead); an
  // empty FIFO has nothing to pop.
  assign w_push = i_push & ~w_full;
  assign w_pop  = ~w_empty & i_ready;

  // Storage has no reset: stale words are harmless because valid is
  // driven from the count, not from the array.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_wdata;
    end
  end

  // Pointers and count; flush and reset both empty the FIFO and win over
  // any push or pop in the same cycle. Pointers wrap by overflow since
  // DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LEVEL_W'(1);
        2'b01:   r_count <= r_count - LEVEL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rdPtr];
  assign o_valid = ~w_empty;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/fifo_mm_to_st_up.sv
// HPS-to-fabric bridge: Avalon-MM write slave feeding a FIFO whose head is
// presented on an Avalon-ST source. Address 0 pushes data, address 1 reads
// the level/flags and accepts a soft-flush command.
module fifo_mm_to_st_up
  import procesador_fifo_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic        wrclock,
  input  logic        reset,
  input  logic        avalonmm_write_slave_address,
  input  logic        avalonmm_write_slave_write,
  input  logic [31:0] avalonmm_write_slave_writedata,
  input  logic        avalonmm_write_slave_read,
  output logic [31:0] avalonmm_write_slave_readdata,
  output logic        avalonmm_write_slave_waitrequest,
  output logic [31:0] avalonst_source_data,
  output logic        avalonst_source_valid,
  input  logic        avalonst_source_ready
);

  logic               w_isData;
  logic               w_isStatus;
  logic               w_push;
  logic               w_flush;
  logic               w_full;
  logic               w_empty;
  logic [LEVEL_W-1:0] w_count;

  assign w_isData   = (avalonmm_write_slave_address == ADDR_DATA);
  assign w_isStatus = (avalonmm_write_slave_address == ADDR_STATUS);

  // Push request is passed through unconditionally; the FIFO ignores it
  // while full and the master is held off by waitrequest instead.
  assign w_push  = avalonmm_write_slave_write & w_isData;
  assign w_flush = avalonmm_write_slave_write & w_isStatus
                 & avalonmm_write_slave_writedata[FLUSH_BIT];

  // Stall only data writes against a full FIFO. A same-cycle pop does not
  // release the stall; the write lands on the following cycle.
  assign avalonmm_write_slave_waitrequest = w_push & w_full;

  fifo_regs_fwft #(
    .DEPTH   (DEPTH),
    .LEVEL_W (LEVEL_W),
    .DATA_W  (32)
  ) u_fifo (
    .i_clk   (wrclock),
    .i_reset (reset),
    .i_push  (w_push),
    .i_wdata (avalonmm_write_slave_writedata),
    .i_ready (avalonst_source_ready),
    .i_flush (w_flush),
    .o_data  (avalonst_source_data),
    .o_valid (avalonst_source_valid),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Status read mux; reads of the data address return zero and have no
  // side effect on the FIFO.
  always_comb begin
    avalonmm_write_slave_readdata = '0;
    if (avalonmm_write_slave_read && w_isStatus) begin
      avalonmm_write_slave_readdata =
        packStatus(w_full, w_empty, STATUS_LEVEL_W'(w_count));
    end
  end

endmodule

// File: tb/tb_fifo_mm_to_st_up.sv
// Directed bench for fifo_mm_to_st_up: a vector table for single-cycle
// behaviour plus hand-written multi-cycle sequences for fill/stall, wrap,
// backpressure, flush and mid-operation reset.
module tb_fifo_mm_to_st_up;

  logic        clock;
  logic        reset;
  logic        mmAddress;
  logic        mmWrite;
  logic [31:0] mmWritedata;
  logic        mmRead;
  logic [31:0] mmReaddata;
  logic        mmWaitrequest;
  logic [31:0] stData;
  logic        stValid;
  logic        stReady;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic        addr;
    logic        wr;
    logic [31:0] wdata;
    logic        rd;
    logic        ready;
    logic        expValid;
    logic [31:0] expData;
    logic        expWait;
    logic [31:0] expRdata;
  } vec_t;

  localparam int NUM_VECS = 20;
  vec_t vecs [NUM_VECS];

  fifo_mm_to_st_up #(
    .DEPTH   (16),
    .LEVEL_W (5)
  ) dut (
    .wrclock                          (clock),
    .reset                            (reset),
    .avalonmm_write_slave_address     (mmAddress),
    .avalonmm_write_slave_write       (mmWrite),
    .avalonmm_write_slave_writedata   (mmWritedata),
    .avalonmm_write_slave_read        (mmRead),
    .avalonmm_write_slave_readdata    (mmReaddata),
    .avalonmm_write_slave_waitrequest (mmWaitrequest),
    .avalonst_source_data             (stData),
    .avalonst_source_valid            (stValid),
    .avalonst_source_ready            (stReady)
  );

  // Free-running clock, 10 time units per cycle
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(
    input logic addr, input logic wr, input logic [31:0] wdata,
    input logic rd, input logic ready, input logic expValid,
    input logic [31:0] expData, input logic expWait,
    input logic [31:0] expRdata
  );
    vec_t v;
    v.addr = addr; v.wr = wr; v.wdata = wdata; v.rd = rd; v.ready = ready;
    v.expValid = expValid; v.expData = expData;
    v.expWait = expWait; v.expRdata = expRdata;
    return v;
  endfunction

  // Inputs change just after the falling edge; outputs settle 1 unit later
  task automatic applyStimulus(
    input logic addr, input logic wr, input logic [31:0] wdata,
    input logic rd, input logic ready
  );
    mmAddress   = addr;
    mmWrite     = wr;
    mmWritedata = wdata;
    mmRead      = rd;
    stReady     = ready;
    #1;
  endtask

  task automatic checkOutput(
    input string name, input logic [31:0] actual, input logic [31:0] expected
  );
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    stepClock();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    mmAddress   = 1'b0;
    mmWrite     = 1'b0;
    mmWritedata = '0;
    mmRead      = 1'b0;
    stReady     = 1'b0;

    //                addr  wr    wdata         rd    rdy   vld   data          wait  rdata
    vecs[0]  = mkVec(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h40);
    vecs[1]  = mkVec(1'b0, 1'b1, 32'h11111111, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0);
    vecs[2]  = mkVec(1'b0, 1'b1, 32'h22222222, 1'b0, 1'b1, 1'b1, 32'h11111111, 1'b0, 32'h0);
    vecs[3]  = mkVec(1'b0, 1'b1, 32'h33333333, 1'b0, 1'b1, 1'b1, 32'h22222222, 1'b0, 32'h0);
    vecs[4]  = mkVec(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h33333333, 1'b0, 32'h0);
    vecs[5]  = mkVec(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h40);
    vecs[6]  = mkVec(1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0);
    vecs[7]  = mkVec(1'b0, 1'b1, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0);
    vecs[8]  = mkVec(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h02);
    vecs[9]  = mkVec(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0);
    vecs[10] = mkVec(1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0);
    vecs[11] = mkVec(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h02);
    vecs[12] = mkVec(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0);
    vecs[13] = mkVec(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h5A5A5A5A, 1'b0, 32'h01);
    vecs[14] = mkVec(1'b1, 1'b1, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h5A5A5A5A, 1'b0, 32'h0);
    vecs[15] = mkVec(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h40);
    vecs[16] = mkVec(1'b0, 1'b1, 32'hABCD0000, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0);
    vecs[17] = mkVec(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hABCD0000, 1'b0, 32'h01);
    vecs[18] = mkVec(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hABCD0000, 1'b0, 32'h0);
    vecs[19] = mkVec(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h40);

    @(negedge clock);
    doReset();

    // Table: pass-through, status reads, ignored control bits, flush vs pop
    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].rd, vecs[i].ready);
      checkOutput($sformatf("vec%0d valid", i), 32'(stValid), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d wait", i), 32'(mmWaitrequest), 32'(vecs[i].expWait));
      checkOutput($sformatf("vec%0d rdata", i), mmReaddata, vecs[i].expRdata);
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d data", i), stData, vecs[i].expData);
      end
      stepClock();
    end

    // Fill and stall
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
      checkOutput("fill wait", 32'(mmWaitrequest), 32'h0);
      stepClock();
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("full status", mmReaddata, 32'h90);
    stepClock();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h1010, 1'b0, 1'b0);
      checkOutput("stall wait", 32'(mmWaitrequest), 32'h1);
      stepClock();
    end
    applyStimulus(1'b0, 1'b1, 32'h1010, 1'b0, 1'b1);
    checkOutput("stall wait with pop", 32'(mmWaitrequest), 32'h1);
    checkOutput("stall head", stData, 32'h1000);
    stepClock();
    applyStimulus(1'b0, 1'b1, 32'h1010, 1'b0, 1'b0);
    checkOutput("stall release", 32'(mmWaitrequest), 32'h0);
    stepClock();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("refull status", mmReaddata, 32'h90);
    stepClock();
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("drain valid", 32'(stValid), 32'h1);
      checkOutput("drain data", stData, 32'h1000 + 32'(i));
      stepClock();
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("drained valid", 32'(stValid), 32'h0);
    checkOutput("drained status", mmReaddata, 32'h40);
    stepClock();

    // Simultaneous push/pop at level 5 across pointer wrap
    doReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 32'h2000 + 32'(k), 1'b0, 1'b0);
      stepClock();
    end
    for (int j = 0; j < 20; j++) begin
      applyStimulus(1'b0, 1'b1, 32'h2005 + 32'(j), 1'b0, 1'b1);
      checkOutput("stream data", stData, 32'h2000 + 32'(j));
      checkOutput("stream wait", 32'(mmWaitrequest), 32'h0);
      stepClock();
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("stream status", mmReaddata, 32'h05);
    checkOutput("stream head", stData, 32'h2014);
    stepClock();

    // Backpressure: head word must hold while ready is low
    doReset();
    applyStimulus(1'b0, 1'b1, 32'hCAFE0001, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 1'b1, 32'hCAFE0002, 1'b0, 1'b0);
    stepClock();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("hold valid", 32'(stValid), 32'h1);
      checkOutput("hold data", stData, 32'hCAFE0001);
      stepClock();
    end

    // Flush at level 9 with ready high
    doReset();
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b0, 1'b1, 32'h3000 + 32'(k), 1'b0, 1'b0);
      stepClock();
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("pre-flush status", mmReaddata, 32'h09);
    stepClock();
    applyStimulus(1'b1, 1'b1, 32'h00000001, 1'b0, 1'b1);
    checkOutput("flush wait", 32'(mmWaitrequest), 32'h0);
    stepClock();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("post-flush valid", 32'(stValid), 32'h0);
    checkOutput("post-flush status", mmReaddata, 32'h40);
    stepClock();
    applyStimulus(1'b0, 1'b1, 32'hABCD0000, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("post-flush first word", stData, 32'hABCD0000);
    stepClock();

    // Reset while the master is stalled on a full FIFO
    doReset();
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, 1'b1, 32'h4000 + 32'(k), 1'b0, 1'b0);
      stepClock();
    end
    applyStimulus(1'b0, 1'b1, 32'h4FFF, 1'b0, 1'b0);
    checkOutput("pre-reset wait", 32'(mmWaitrequest), 32'h1);
    reset = 1'b1;
    stepClock();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("post-reset valid", 32'(stValid), 32'h0);
    checkOutput("post-reset status", mmReaddata, 32'h40);
    stepClock();
    applyStimulus(1'b0, 1'b1, 32'h00000077, 1'b0, 1'b0);
    checkOutput("post-reset wait", 32'(mmWaitrequest), 32'h0);
    stepClock();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("post-reset word valid", 32'(stValid), 32'h1);
    checkOutput("post-reset word data", stData, 32'h00000077);
    checkOutput("post-reset level", mmReaddata, 32'h01);
    stepClock();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
